// File: rtl/seq_gen_1011.sv
// +--------------------------------------------------------------------------+
// | Module   : seq_gen_1011                                                  |
// | Brief    : Repeating serial pattern generator with gaps, valid/ready     |
// |            handshake, abort and a one-cycle completion pulse.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_gen_1011 #(
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter int                   CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [3:0]       gap_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0] c_IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] c_REP_ZERO = '0;
  localparam logic [CNT_W-1:0] c_REP_ONE  = CNT_W'(1);
  localparam logic [3:0]       c_GAP_ZERO = 4'd0;
  localparam logic [3:0]       c_GAP_ONE  = 4'd1;

  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [CNT_W-1:0] rep_q,     rep_d;
  logic [3:0]       gap_len_q, gap_len_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= c_IDLE;
      idx_q     <= c_IDX_ZERO;
      rep_q     <= c_REP_ZERO;
      gap_len_q <= c_GAP_ZERO;
      gap_cnt_q <= c_GAP_ZERO;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state and counter logic; counters only move on a transfer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      c_IDLE: begin
        if (start) begin
          if (rep_count != c_REP_ZERO) begin
            state_d   = c_SEND;
            idx_d     = c_IDX_LAST;
            rep_d     = rep_count;
            gap_len_d = gap_len;
            gap_cnt_d = c_GAP_ZERO;
          end else begin
            state_d = c_DONE;
          end
        end
      end

      c_SEND: begin
        if (abort) begin
          state_d   = c_IDLE;
          idx_d     = c_IDX_ZERO;
          rep_d     = c_REP_ZERO;
          gap_cnt_d = c_GAP_ZERO;
        end else if (out_ready) begin
          if (idx_q == c_IDX_ZERO) begin
            // rep_q holds the repetitions still owed, including this one
            if (rep_q == c_REP_ONE) begin
              state_d = c_DONE;
              rep_d   = c_REP_ZERO;
            end else begin
              rep_d = rep_q - c_REP_ONE;
              if (gap_len_q != c_GAP_ZERO) begin
                state_d   = c_GAP;
                gap_cnt_d = gap_len_q;
              end else begin
                idx_d = c_IDX_LAST;
              end
            end
          end else begin
            idx_d = idx_q - c_IDX_ONE;
          end
        end
      end

      c_GAP: begin
        if (abort) begin
          state_d   = c_IDLE;
          idx_d     = c_IDX_ZERO;
          rep_d     = c_REP_ZERO;
          gap_cnt_d = c_GAP_ZERO;
        end else if (out_ready) begin
          if (gap_cnt_q == c_GAP_ONE) begin
            state_d   = c_SEND;
            idx_d     = c_IDX_LAST;
            gap_cnt_d = c_GAP_ZERO;
          end else begin
            gap_cnt_d = gap_cnt_q - c_GAP_ONE;
          end
        end
      end

      c_DONE: begin
        state_d = c_IDLE;
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so start never reaches them combinationally
  always_comb begin
    out_bit     = 1'b0;
    out_valid   = 1'b0;
    frame_start = 1'b0;
    busy        = (state_q != c_IDLE);
    done        = 1'b0;

    case (state_q)
      c_SEND: begin
        out_valid   = 1'b1;
        out_bit     = PATTERN[idx_q];
        frame_start = (idx_q == c_IDX_LAST);
      end
      c_GAP: begin
        out_valid = 1'b1;
      end
      c_DONE: begin
        done = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_1011.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_gen_1011                                               |
// | Brief    : Scoreboard bench for seq_gen_1011 with a stream-level model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_gen_1011;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] rep_count;
  logic [3:0]       gap_len;
  logic             abort;
  logic             out_ready;
  logic             out_bit;
  logic             out_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;

  // Each entry is {expected out_bit, expected frame_start} for one transfer
  logic [1:0] exp_q[$];

  seq_gen_1011 #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (4'b1011),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rep_count   (rep_count),
    .gap_len     (gap_len),
    .abort       (abort),
    .out_ready   (out_ready),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks output invariants
  initial begin
    logic       prev_stall;
    logic [1:0] prev_out;
    logic [1:0] e;
    prev_stall = 1'b0;
    prev_out   = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", {7'd0, out_valid}, 8'd1);
          check("stall_hold_data", {6'd0, out_bit, frame_start}, {6'd0, prev_out});
        end
        if (out_valid && out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_transfer", {6'd0, out_bit, frame_start}, 8'hff);
          end else begin
            e = exp_q.pop_front();
            check("stream_bit_frame", {6'd0, out_bit, frame_start}, {6'd0, e});
          end
          n_xfer++;
        end
        if (!busy)
          check("idle_outputs", {4'd0, out_valid, out_bit, frame_start, done}, 8'd0);
        if (done)
          check("done_no_valid", {6'd0, out_valid, frame_start}, 8'd0);
        prev_stall = out_valid && !out_ready && !abort;
        prev_out   = {out_bit, frame_start};
      end
    end
  end

  // mode 0: always ready, 1: random ready and stray start, 2: 3-cycle stall on 2nd bit
  task automatic run_txn(input int rep, input int gap, input int mode, input int abort_at);
    logic [3:0] pat;
    int         base, cyc, stall, lat_exp;
    bit         got_done, aborted, abort_now, quiet;
    pat = 4'b1011;
    for (int r = 0; r < rep; r++) begin
      for (int i = PAT_LEN - 1; i >= 0; i--)
        exp_q.push_back({pat[i], (i == PAT_LEN - 1)});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(2'b00);
    end
    lat_exp  = (rep == 0) ? 1 : rep * PAT_LEN + (rep - 1) * gap + 1 + ((mode == 2) ? 3 : 0);
    base     = n_xfer;
    cyc      = 0;
    stall    = 0;
    got_done = 1'b0;
    aborted  = 1'b0;

    @(posedge clk); #1;
    start     = 1'b1;
    rep_count = rep[CNT_W-1:0];
    gap_len   = gap[3:0];
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (!got_done && !aborted && cyc < 4000) begin
      abort_now = (abort_at >= 0) && ((n_xfer - base) == abort_at) && (exp_q.size() > 0);
      // rep=0 sits in DONE on its first cycle: abort there must be ignored
      abort = abort_now || (rep == 0 && cyc == 0);
      case (mode)
        1: begin
          out_ready = 1'($urandom_range(0, 1));
          start     = !abort_now && ($urandom_range(0, 7) == 0);
          rep_count = CNT_W'($urandom_range(0, 255));
        end
        2: begin
          out_ready = !(((n_xfer - base) == 1) && stall < 3);
          if (!out_ready) stall++;
        end
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      cyc++;
      if (done) got_done = 1'b1;
      if (abort_now) begin
        exp_q.delete();
        aborted = 1'b1;
      end
      if (!got_done && !aborted) begin
        @(posedge clk); #1;
      end
    end

    if (aborted) begin
      start = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_to_idle", {5'd0, busy, out_valid, done}, 8'd0);
      quiet = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done || busy) quiet = 1'b0;
      end
      check("abort_no_done", {7'd0, quiet}, 8'd1);
    end else if (got_done) begin
      start = 1'b0;
      abort = 1'b0;
      check("all_bits_sent", 8'(exp_q.size()), 8'd0);
      if (mode != 1) check("done_latency", 8'(cyc), 8'(lat_exp));
      @(negedge clk);
      check("done_one_cycle", {6'd0, done, busy}, 8'd0);
    end else begin
      start = 1'b0;
      abort = 1'b0;
      check("timeout_waiting_done", 8'd0, 8'd1);
      exp_q.delete();
    end
    out_ready = 1'b1;
  endtask

  task automatic reset_mid_txn();
    logic [3:0] pat;
    int         base, cyc;
    pat = 4'b1011;
    for (int i = PAT_LEN - 1; i >= 0; i--)
      exp_q.push_back({pat[i], (i == PAT_LEN - 1)});
    base = n_xfer;
    @(posedge clk); #1;
    start = 1'b1; rep_count = 8'd1; gap_len = 4'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((n_xfer - base) < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("third_bit_reached", 8'(n_xfer - base), 8'd2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {3'd0, busy, out_valid, out_bit, frame_start, done}, 8'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", {6'd0, done, busy}, 8'd0);
  endtask

  initial begin
    int rep, gap, total, abort_at;
    reset     = 1'b0;
    start     = 1'b0;
    rep_count = '0;
    gap_len   = 4'd0;
    abort     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset_outputs", {3'd0, busy, out_valid, out_bit, frame_start, done}, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_txn(1, 0, 0, -1);
    run_txn(2, 2, 0, -1);
    run_txn(3, 0, 0, -1);
    run_txn(1, 0, 2, -1);
    run_txn(0, 3, 0, -1);
    run_txn(4, 1, 0, 4);
    run_txn(255, 0, 0, -1);
    reset_mid_txn();
    run_txn(1, 0, 0, -1);

    for (int t = 0; t < 30; t++) begin
      rep      = int'($urandom_range(0, 5));
      gap      = int'($urandom_range(0, 3));
      total    = rep * PAT_LEN + ((rep > 0) ? (rep - 1) * gap : 0);
      abort_at = (total > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      run_txn(rep, gap, 1, abort_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_gen_1011.md
SEQ_GEN_1011 -- requirements
Module: seq_gen_1011

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, giving the number of bits per pattern.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, giving the pattern to transmit, MSB first.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the repetition count.
REQ-004 Port clk: input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-006 Port start: input, 1 bit, request to begin a transmission; sampled only in IDLE.
REQ-007 Port rep_count: input, CNT_W bits, number of pattern repetitions; captured when start is accepted.
REQ-008 Port gap_len: input, 4 bits, number of 0-bits inserted between repetitions; captured when start is accepted.
REQ-009 Port abort: input, 1 bit, synchronous cancel of the transmission in progress.
REQ-010 Port out_ready: input, 1 bit, sink accepts out_bit this cycle.
REQ-011 Port out_bit: output, 1 bit, serial data.
REQ-012 Port out_valid: output, 1 bit, out_bit is meaningful.
REQ-013 Port frame_start: output, 1 bit, high while out_bit is the first bit of a pattern.
REQ-014 Port busy: output, 1 bit, high in every state except IDLE.
REQ-015 Port done: output, 1 bit, one-cycle pulse when a transmission has completed.

Function
REQ-016 The block SHALL implement the states IDLE, SEND, GAP and DONE, encoded in a registered state variable with combinational next-state logic.
REQ-017 The block SHALL define a transfer as a cycle with out_valid=1 and out_ready=1; the bit index and gap counter SHALL advance only on a transfer.
REQ-018 While out_valid=1 and out_ready=0, out_bit and frame_start SHALL remain stable.
REQ-019 In IDLE with start=1 and rep_count>0, the block SHALL capture rep_count and gap_len and enter SEND on the next edge with bit index PAT_LEN-1.
REQ-020 In IDLE with start=1 and rep_count=0, the block SHALL enter DONE directly and SHALL NOT assert out_valid.
REQ-021 In SEND, out_valid SHALL be 1 and out_bit SHALL equal PATTERN[bit index].
REQ-022 In SEND, frame_start SHALL be 1 when bit index = PAT_LEN-1.
REQ-023 On a transfer of bit index 0, if this was the last repetition the block SHALL go to DONE.
REQ-024 On a transfer of bit index 0, if this was not the last repetition and the captured gap_len>0, the block SHALL go to GAP.
REQ-025 On a transfer of bit index 0, if this was not the last repetition and the captured gap_len=0, the block SHALL go to SEND with bit index PAT_LEN-1, so that patterns run back-to-back with no bubble.
REQ-026 In GAP, out_valid SHALL be 1 and out_bit SHALL be 0; after exactly gap_len transfers the block SHALL return to SEND with bit index PAT_LEN-1.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-028 start asserted in any state other than IDLE SHALL be ignored.
REQ-029 abort=1 in SEND or GAP SHALL force IDLE on the next edge with no done pulse; abort SHALL have priority over out_ready.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 The repetition counter SHALL decrement once per completed pattern; rep_count = 2^CNT_W-1 SHALL be transmitted in full with no wrap-around.
REQ-032 In IDLE and DONE, out_valid and frame_start SHALL be 0 and out_bit SHALL be 0.
REQ-033 All outputs SHALL be driven from registered state and counters, with no combinational path from start to any output.

Reset
REQ-034 On reset=0 the block SHALL immediately enter IDLE, clear all counters, and drive out_bit=0, out_valid=0, frame_start=0, busy=0 and done=0.
REQ-035 Reset asserted mid-transmission SHALL discard that transmission with no done pulse; the first start after reset deasserts SHALL begin a fresh transmission.

Verification
REQ-036 Single pattern: rep_count=1, gap_len=0, out_ready=1 -> out_bit 1,0,1,1 on cycles 1-4 with frame_start only on cycle 1; done=1 on cycle 5; busy=0 on cycle 6.
REQ-037 Repeat with gap: rep_count=2, gap_len=2 -> stream 1,0,1,1,0,0,1,0,1,1 with no bubbles, then a done pulse; fed to the 1011 detector this produces exactly 2 seq_seen pulses.
REQ-038 Back-to-back: rep_count=3, gap_len=0 -> 12 contiguous valid bits 101110111011, frame_start on bits 1, 5 and 9.
REQ-039 Backpressure: rep_count=1, out_ready=0 for 3 cycles while bit 2 (0) is presented -> out_bit holds 0 and out_valid holds 1; the full sequence 1011 completes 3 cycles late.
REQ-040 Zero count and abort: rep_count=0 -> done the cycle after start with no valid bits; abort during GAP of rep_count=4 -> IDLE next cycle, no done pulse.
REQ-041 Async reset: reset=0 during bit 3 -> out_valid=0 and busy=0 before the next clk edge; a new start after reset produces 1011 from the first bit.
